// File: rtl/mips_pkg.sv
// Shared MIPS definitions: access-width encodings, byte-lane count and the
// MEM/WB control bundle carried through the memory stage.
package mips_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

    localparam int NB_BYTE_LANES = 4;

    typedef struct packed {
        logic       mem2reg;
        logic       reg_write;
        logic [4:0] write_reg;
        logic       misaligned;
    } memwb_ctrl_t;

endpackage

// File: rtl/data_memory.sv
// Little-endian data memory: one byte array per lane with synchronous
// per-lane write, a combinational data read port and a registered debug port.
module data_memory
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [NB_BYTE_LANES-1:0] i_we,
    input  logic [NB_ADDR-3:0]       i_addr,
    input  logic [NB_DATA-1:0]       i_wdata,
    output logic [NB_DATA-1:0]       o_rdata,
    input  logic [NB_ADDR-3:0]       i_dbg_addr,
    output logic [NB_DATA-1:0]       o_dbg_data
);

    localparam int DEPTH   = 2 ** (NB_ADDR - 2);
    localparam int NB_LANE = NB_DATA / NB_BYTE_LANES;

    logic [NB_DATA-1:0] dbg_word;
    logic [NB_DATA-1:0] dbg_data_reg;

    // Each lane owns its own array so a partial store touches only its bytes.
    // Writes are dropped while reset is asserted so an interrupted store
    // leaves the word at its previous value.
    generate
        for (genvar gi = 0; gi < NB_BYTE_LANES; gi++) begin : g_lane
            logic [NB_LANE-1:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (i_rst_n && i_we[gi]) begin
                    lane_mem[i_addr] <= i_wdata[gi*NB_LANE +: NB_LANE];
                end
            end

            assign o_rdata[gi*NB_LANE +: NB_LANE]  = lane_mem[i_addr];
            assign dbg_word[gi*NB_LANE +: NB_LANE] = lane_mem[i_dbg_addr];
        end
    endgenerate

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbg_data_reg <= '0;
        end else begin
            dbg_data_reg <= dbg_word;
        end
    end

    assign o_dbg_data = dbg_data_reg;

endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: alignment check, store lane steering, load lane selection
// with sign/zero extension, and the MEM/WB pipeline registers.
module memory_access
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_ADDR-3:0] i_dbg_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_dbg_data
);

    logic [NB_ADDR-1:0]       addr;
    logic [NB_ADDR-3:0]       word_idx;
    logic [1:0]               byte_off;
    logic                     hold;
    logic                     aligned;
    logic [NB_BYTE_LANES-1:0] lane_mask;
    logic [NB_BYTE_LANES-1:0] mem_we;
    logic [NB_DATA-1:0]       mem_wdata;
    logic [NB_DATA-1:0]       rd_word;
    logic [7:0]               rd_byte;
    logic [15:0]              rd_half;
    logic [NB_DATA-1:0]       load_next;
    memwb_ctrl_t              ctrl_next;

    memwb_ctrl_t              ctrl_reg;
    logic [NB_DATA-1:0]       result_reg;
    logic [NB_DATA-1:0]       read_data_reg;

    // Only the low NB_ADDR bits of the effective address reach the memory.
    logic unused_result_bits;
    assign unused_result_bits = ^i_result[NB_DATA-1:NB_ADDR];

    assign addr     = i_result[NB_ADDR-1:0];
    assign word_idx = addr[NB_ADDR-1:2];
    assign byte_off = addr[1:0];
    assign hold     = i_stall | i_halt;

    // Width 2'b10 falls into the default arm and behaves as a word access.
    always_comb begin
        aligned   = 1'b1;
        lane_mask = '1;
        mem_wdata = i_data4Mem;
        case (i_width)
            W_BYTE: begin
                aligned   = 1'b1;
                lane_mask = 4'b0001 << byte_off;
                mem_wdata = {NB_BYTE_LANES{i_data4Mem[7:0]}};
            end
            W_HALF: begin
                aligned   = ~byte_off[0];
                lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{i_data4Mem[15:0]}};
            end
            default: begin
                aligned   = (byte_off == 2'b00);
                lane_mask = '1;
                mem_wdata = i_data4Mem;
            end
        endcase
    end

    assign mem_we = (i_memWrite && aligned && !hold) ? lane_mask : '0;

    data_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_data_memory (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_we       (mem_we),
        .i_addr     (word_idx),
        .i_wdata    (mem_wdata),
        .o_rdata    (rd_word),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half = rd_word[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        load_next = '0;
        if (i_memRead && aligned) begin
            case (i_width)
                W_BYTE:  load_next = {{(NB_DATA-8){i_sign_flag & rd_byte[7]}}, rd_byte};
                W_HALF:  load_next = {{(NB_DATA-16){i_sign_flag & rd_half[15]}}, rd_half};
                default: load_next = rd_word;
            endcase
        end
    end

    always_comb begin
        ctrl_next            = '0;
        ctrl_next.mem2reg    = i_mem2reg;
        ctrl_next.reg_write  = i_regWrite;
        ctrl_next.write_reg  = i_write_reg;
        ctrl_next.misaligned = (i_memRead | i_memWrite) & ~aligned;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_reg      <= '0;
            result_reg    <= '0;
            read_data_reg <= '0;
        end else if (!hold) begin
            ctrl_reg      <= ctrl_next;
            result_reg    <= i_result;
            read_data_reg <= load_next;
        end
    end

    assign o_mem2reg    = ctrl_reg.mem2reg;
    assign o_regWrite   = ctrl_reg.reg_write;
    assign o_write_reg  = ctrl_reg.write_reg;
    assign o_misaligned = ctrl_reg.misaligned;
    assign o_result     = result_reg;
    assign o_read_data  = read_data_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: expected MEM/WB values are queued as each
// step is driven and compared one cycle later.
module tb_memory_access;

    logic        clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_halt;
    logic        i_mem2reg;
    logic        i_memRead;
    logic        i_memWrite;
    logic        i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic [4:0]  i_write_reg;
    logic [31:0] i_result;
    logic [31:0] i_data4Mem;
    logic [7:0]  i_dbg_addr;
    logic        o_mem2reg;
    logic        o_regWrite;
    logic [4:0]  o_write_reg;
    logic [31:0] o_result;
    logic [31:0] o_read_data;
    logic        o_misaligned;
    logic [31:0] o_dbg_data;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic [31:0] res;
        logic [4:0]  wr;
        logic        rw;
        logic        m2r;
        logic [31:0] dbg;
        logic        chk_dbg;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    exp_t zero_exp;
    int   n_checks;
    int   n_errors;

    memory_access #(.NB_DATA(32), .NB_ADDR(10)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_halt       (i_halt),
        .i_mem2reg    (i_mem2reg),
        .i_memRead    (i_memRead),
        .i_memWrite   (i_memWrite),
        .i_regWrite   (i_regWrite),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_write_reg  (i_write_reg),
        .i_result     (i_result),
        .i_data4Mem   (i_data4Mem),
        .i_dbg_addr   (i_dbg_addr),
        .o_mem2reg    (o_mem2reg),
        .o_regWrite   (o_regWrite),
        .o_write_reg  (o_write_reg),
        .o_result     (o_result),
        .o_read_data  (o_read_data),
        .o_misaligned (o_misaligned),
        .o_dbg_data   (o_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input string field,
                           input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check32(tag, "read_data", o_read_data, e.rd);
        check32(tag, "misaligned", 32'(o_misaligned), 32'(e.mis));
        check32(tag, "result", o_result, e.res);
        check32(tag, "write_reg", 32'(o_write_reg), 32'(e.wr));
        check32(tag, "regWrite", 32'(o_regWrite), 32'(e.rw));
        check32(tag, "mem2reg", 32'(o_mem2reg), 32'(e.m2r));
        if (e.chk_dbg) check32(tag, "dbg_data", o_dbg_data, e.dbg);
        $display("step %-14s rd=%h mis=%0b res=%h dbg=%h", tag, o_read_data, o_misaligned, o_result, o_dbg_data);
        last_exp = e;
    endtask

    // Drive one instruction, queue what MEM/WB should show after the edge.
    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic [1:0] w, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [7:0] dbg_idx, input logic stall, input logic halt,
                        input logic [31:0] exp_rd, input logic exp_mis,
                        input logic [31:0] exp_dbg, input logic chk_dbg);
        exp_t e;
        i_memRead   = rd;
        i_memWrite  = wr;
        i_mem2reg   = rd;
        i_regWrite  = rd;
        i_write_reg = addr[4:0];
        i_width     = w;
        i_sign_flag = sgn;
        i_result    = addr;
        i_data4Mem  = data;
        i_dbg_addr  = dbg_idx;
        i_stall     = stall;
        i_halt      = halt;
        if (stall || halt) begin
            e = last_exp;
        end else begin
            e.rd  = exp_rd;
            e.mis = exp_mis;
            e.res = addr;
            e.wr  = addr[4:0];
            e.rw  = rd;
            e.m2r = rd;
        end
        e.dbg     = exp_dbg;
        e.chk_dbg = chk_dbg;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        zero_exp = '{rd: 32'h0, mis: 1'b0, res: 32'h0, wr: 5'h0, rw: 1'b0,
                     m2r: 1'b0, dbg: 32'h0, chk_dbg: 1'b1};
        i_rst_n     = 1'b0;
        i_stall     = 1'b0;
        i_halt      = 1'b0;
        i_mem2reg   = 1'b0;
        i_memRead   = 1'b0;
        i_memWrite  = 1'b0;
        i_regWrite  = 1'b0;
        i_width     = 2'b00;
        i_sign_flag = 1'b0;
        i_write_reg = 5'h0;
        i_result    = 32'h0;
        i_data4Mem  = 32'h0;
        i_dbg_addr  = 8'h0;

        #12;
        sb_q.push_back(zero_exp);
        check_all("reset");
        @(negedge clk);
        i_rst_n = 1'b1;

        //    tag          rd   wr   width  sgn  addr    data          dbg    st   ht   exp_rd        mis  exp_dbg       chk
        step("st_w_10",    1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 8'h04, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
        step("st_w_20",    1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h11111111, 8'h04, 1'b0, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1);
        step("ld_w_10",    1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        8'h08, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h11111111, 1'b1);
        step("ld_bs_11",   1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        8'h04, 1'b0, 1'b0, 32'hFFFFFFBE, 1'b0, 32'hDEADBEEF, 1'b1);
        step("ld_bu_11",   1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        8'h04, 1'b0, 1'b0, 32'h000000BE, 1'b0, 32'hDEADBEEF, 1'b1);
        step("st_h_12",    1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 8'h04, 1'b0, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1);
        step("ld_w_10b",   1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        8'h04, 1'b0, 1'b0, 32'h1234BEEF, 1'b0, 32'h1234BEEF, 1'b1);
        step("ld_hs_12",   1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        8'h04, 1'b0, 1'b0, 32'h00001234, 1'b0, 32'h1234BEEF, 1'b1);
        step("ld_hs_10",   1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        8'h04, 1'b0, 1'b0, 32'hFFFFBEEF, 1'b0, 32'h1234BEEF, 1'b1);
        step("ld_hu_10",   1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        8'h04, 1'b0, 1'b0, 32'h0000BEEF, 1'b0, 32'h1234BEEF, 1'b1);
        step("ld_w2_10",   1'b1, 1'b0, 2'b10, 1'b0, 32'hF010, 32'h0,      8'h04, 1'b0, 1'b0, 32'h1234BEEF, 1'b0, 32'h1234BEEF, 1'b1);
        step("ld_bs_13",   1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        8'h04, 1'b0, 1'b0, 32'h00000012, 1'b0, 32'h1234BEEF, 1'b1);
        step("ld_w_13",    1'b1, 1'b0, 2'b11, 1'b0, 32'h13, 32'h0,        8'h04, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1234BEEF, 1'b1);
        step("st_h_11",    1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 8'h04, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1234BEEF, 1'b1);
        step("nop_dbg",    1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        8'h04, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1234BEEF, 1'b1);
        step("ld_w_20",    1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        8'h08, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h11111111, 1'b1);
        step("stall_st",   1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D, 8'h08, 1'b1, 1'b0, 32'h0,        1'b0, 32'h11111111, 1'b1);
        step("post_stall", 1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        8'h08, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h11111111, 1'b1);
        step("halt_ld",    1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        8'h04, 1'b0, 1'b1, 32'h0,        1'b0, 32'h1234BEEF, 1'b1);
        step("halt_st",    1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFEF00D, 8'h04, 1'b1, 1'b1, 32'h0,        1'b0, 32'h1234BEEF, 1'b1);

        // Reset between edges, with a store presented across the reset edge.
        #2;
        i_rst_n    = 1'b0;
        i_stall    = 1'b0;
        i_halt     = 1'b0;
        i_memRead  = 1'b0;
        i_memWrite = 1'b1;
        i_width    = 2'b11;
        i_result   = 32'h10;
        i_data4Mem = 32'h55555555;
        #1;
        sb_q.push_back(zero_exp);
        check_all("rst_async");
        @(posedge clk);
        #1;
        sb_q.push_back(zero_exp);
        check_all("rst_edge");
        @(negedge clk);
        i_rst_n  = 1'b1;
        last_exp = zero_exp;

        step("ld_after_rst", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,      8'h04, 1'b0, 1'b0, 32'h1234BEEF, 1'b0, 32'h1234BEEF, 1'b1);
        step("ld_w_20_rst",  1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0,      8'h08, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h11111111, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. It takes the registered ALU result (the effective address or the arithmetic result) and the store data. It performs byte, halfword or word loads and stores against a little-endian data memory, with sign or zero extension on loads. It registers the MEM/WB pipeline values and provides a registered debug read port that the debug unit uses while the processor is halted.

## Interface
Parameters:
- NB_DATA, 32, datapath width.
- NB_ADDR, 10, byte-address bits used (memory holds 2^(NB_ADDR-2) words).

Ports:
- clk  in  1  pipeline clock.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_stall  in  1  hold the stage; suppress memory writes.
- i_halt  in  1  processor halted; same effect as i_stall.
- i_mem2reg  in  1  write-back selects load data.
- i_memRead  in  1  load instruction.
- i_memWrite  in  1  store instruction.
- i_regWrite  in  1  register-file write enable, passed through.
- i_width  in  2  access width: 00 byte, 01 halfword, 11 word, 10 treated as word.
- i_sign_flag  in  1  1 = sign-extend loads, 0 = zero-extend.
- i_write_reg  in  5  destination register, passed through.
- i_result  in  NB_DATA  ALU result / effective address.
- i_data4Mem  in  NB_DATA  store data.
- i_dbg_addr  in  NB_ADDR-2  debug word address.
- o_mem2reg  out  1  registered i_mem2reg.
- o_regWrite  out  1  registered i_regWrite.
- o_write_reg  out  5  registered i_write_reg.
- o_result  out  NB_DATA  registered i_result.
- o_read_data  out  NB_DATA  registered, extended load data.
- o_misaligned  out  1  registered flag: the current instruction was a misaligned access.
- o_dbg_data  out  NB_DATA  registered word at i_dbg_addr.

## Operation
Addressing:
- addr = i_result[NB_ADDR-1:0].
- Word index = addr[NB_ADDR-1:2].
- Upper bits of i_result are ignored.

Alignment:
- Halfword accesses require addr[0]=0.
- Word accesses require addr[1:0]=00.
- Byte accesses are always aligned.

Stores (i_memWrite=1, aligned, no stall/halt):
- Byte: i_data4Mem[7:0] is written to lane addr[1:0].
- Halfword: i_data4Mem[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
- Word: all 4 lanes are written.
- All other lanes are untouched.

Loads (i_memRead=1):
- The word is read combinationally and the lane(s) are selected by addr.
- Byte and halfword results are extended per i_sign_flag; word results are passed through unchanged.
- A misaligned load returns 0.
- o_read_data is 0 when i_memRead=0.

Misaligned accesses (load or store):
- The store is suppressed and the load returns 0.
- o_misaligned=1 for that instruction's cycle.
- The pipeline continues; there are no exceptions.

Stall and halt:
- i_stall or i_halt (either or both) holds every pipeline output and blocks memory writes.
- o_dbg_data keeps updating every cycle regardless.

Reset:
- Reset clears every registered output to 0.
- Memory contents are not reset. A reset asserted mid-write aborts that write, and the word holds its prior value.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- A store commits at the edge on which it is presented. A load presented in the following cycle sees the new data.
- The debug read is registered: i_dbg_addr at edge N gives o_dbg_data after edge N.
- If a debug read and a store hit the same word at the same edge, o_dbg_data returns the pre-store value.
- Load and store are never asserted together. If they are, the store takes effect and o_read_data is the pre-store value.
- Reset values: o_mem2reg 0, o_regWrite 0, o_write_reg 0, o_result 0, o_read_data 0, o_misaligned 0, o_dbg_data 0.

## Structure
Shared package mips_pkg:
- Width encodings W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b11.
- Lane-count constant NB_BYTE_LANES=4.

Sub-module data_memory:
- Word array with a 4-bit byte write enable and synchronous write.
- Combinational data read port.
- Registered debug read port.

Lane selection, extension, alignment checking and the MEM/WB registers live in memory_access.

## Test plan
- Word store/load: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> o_read_data=0xDEADBEEF one cycle later, o_misaligned=0.
- Byte loads: after the previous store, signed byte load at 0x11 -> 0xFFFFFFBE; unsigned byte load at 0x11 -> 0x000000BE.
- Halfword store: store halfword 0x00001234 at 0x12, then load word at 0x10 -> 0x1234BEEF. Signed halfword load at 0x12 -> 0x00001234.
- Misaligned: load word at 0x13 -> o_read_data=0, o_misaligned=1. Store halfword 0xFFFF at 0x11 -> word at 0x10 is unchanged (0x1234BEEF on the debug port).
- Stall/halt: present store word 0xCAFEF00D at 0x20 with i_stall=1 -> memory unchanged and outputs held. With i_halt=1, debug read of word index 0x04 -> o_dbg_data=0x1234BEEF.
- Reset mid-run: assert i_rst_n=0 between edges -> all outputs 0 immediately. After release, load word at 0x10 -> 0x1234BEEF, confirming memory is retained.
